// File: rtl/c17_resp_misr.sv
// c17_resp_misr: response-compaction stage for the c17 aging bench.
// Folds each settled CUT response (N22, N23) into a multiple-input signature
// register over a fixed-length run, then reports the signature, the number of
// accepted responses and a pass/fail compare against a golden signature.
//
// Optional feature: define MISR_TIMEOUT_EN to build an idle watchdog that ends
// a run (with timeout_o=1, fail_o=1) after TIMEOUT_CYCLES cycles in a row
// without resp_valid_i. Without the macro timeout_o is tied low.
//
// Ports:
//   clk          bench clock, rising edge active
//   rst_n        asynchronous active-low reset
//   start_i      single-cycle pulse that begins a run (ignored while busy)
//   resp_valid_i resp_i carries a settled CUT response this cycle
//   resp_i       CUT response; [1]=N22, [0]=N23
//   golden_sig_i expected signature, must be stable while done_o=1
//   busy_o       run in progress
//   done_o       run finished, signature and count frozen
//   signature_o  current MISR contents
//   vec_count_o  responses accepted this run
//   pass_o       done and signature matches golden (and no timeout)
//   fail_o       done and signature mismatches or watchdog expired
//   timeout_o    watchdog expired
module c17_resp_misr #(
    parameter int unsigned OUT_WIDTH      = 2,
    parameter int unsigned SIG_WIDTH      = 16,
    parameter int unsigned VEC_LENGTH     = 16,
    parameter logic [SIG_WIDTH-1:0] POLY  = 16'h1021,
    parameter logic [SIG_WIDTH-1:0] SEED  = 16'h0000,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned CNT_W         = $clog2(VEC_LENGTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 resp_valid_i,
    input  logic [OUT_WIDTH-1:0] resp_i,
    input  logic [SIG_WIDTH-1:0] golden_sig_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [SIG_WIDTH-1:0] signature_o,
    output logic [CNT_W-1:0]     vec_count_o,
    output logic                 pass_o,
    output logic                 fail_o,
    output logic                 timeout_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LENGTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SIG_WIDTH-1:0] resp_ext;
    logic [SIG_WIDTH-1:0] sig_next;
    logic                 sig_match;

    always_comb begin
        resp_ext                = '0;
        resp_ext[OUT_WIDTH-1:0] = resp_i;
    end

    // Shift left, fold the polynomial in when the MSB falls out, XOR in response.
    assign sig_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                    ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                    ^ resp_ext;

`ifdef MISR_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
`ifdef MISR_TIMEOUT_EN
        idle_d    = idle_q;
        timeout_d = timeout_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start_i) begin
                    state_d = StRun;
                    sig_d   = SEED;
                    cnt_d   = '0;
`ifdef MISR_TIMEOUT_EN
                    idle_d    = '0;
                    timeout_d = 1'b0;
`endif
                end
            end
            StRun: begin
                if (resp_valid_i) begin
                    sig_d = sig_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = StDone;
                    end
`ifdef MISR_TIMEOUT_EN
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sig_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MISR_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign busy_o      = (state_q == StRun);
    assign done_o      = (state_q == StDone);
    assign signature_o = sig_q;
    assign vec_count_o = cnt_q;
    assign sig_match   = (sig_q == golden_sig_i);
    // A watchdog-terminated run never passes, whatever the signature.
    assign pass_o      = done_o & sig_match & ~timeout_o;
    assign fail_o      = done_o & (~sig_match | timeout_o);

endmodule

// File: tb/tb_c17_resp_misr.sv
// Directed self-checking bench for c17_resp_misr (default parameters).
// Inputs are driven on the falling edge and outputs sampled there too, half a
// period away from the active rising edge.
module tb_c17_resp_misr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        resp_valid;
    logic [1:0]  resp;
    logic [15:0] golden_sig;
    logic        busy;
    logic        done;
    logic [15:0] signature;
    logic [4:0]  vec_count;
    logic        pass;
    logic        fail;
    logic        timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    c17_resp_misr dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .resp_valid_i (resp_valid),
        .resp_i       (resp),
        .golden_sig_i (golden_sig),
        .busy_o       (busy),
        .done_o       (done),
        .signature_o  (signature),
        .vec_count_o  (vec_count),
        .pass_o       (pass),
        .fail_o       (fail),
        .timeout_o    (timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the falling edge, then present one cycle of inputs.
    task automatic step(input logic st, input logic v, input logic [1:0] r);
        @(negedge clk);
        start      = st;
        resp_valid = v;
        resp       = r;
    endtask

    // Full 16-response run: first response 'first', the rest 2'b00.
    // Optionally insert an idle cycle before every response and pulse start mid-run.
    task automatic do_run(input logic [1:0] first, input bit gapped, input bit mid_start);
        step(1'b1, 1'b0, 2'b00);
        for (int i = 0; i < 16; i++) begin
            if (gapped) step(mid_start && (i == 8), 1'b0, 2'b00);
            step(1'b0, 1'b1, (i == 0) ? first : 2'b00);
        end
        step(1'b0, 1'b0, 2'b00);
    endtask

    task automatic check_outputs(input string tag, input logic b, input logic d,
                                 input logic [15:0] s, input logic [4:0] c);
        check_eq({tag, ".busy"}, 32'(busy), 32'(b));
        check_eq({tag, ".done"}, 32'(done), 32'(d));
        check_eq({tag, ".sig"}, 32'(signature), 32'(s));
        check_eq({tag, ".cnt"}, 32'(vec_count), 32'(c));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        resp_valid = 1'b0;
        resp       = 2'b00;
        golden_sig = 16'h0000;
        #12;
        check_outputs("reset", 1'b0, 1'b0, 16'h0000, 5'd0);
        check_eq("reset.pass_fail", 32'({pass, fail, timeout}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Abort a run after 5 responses with an asynchronous reset.
        step(1'b1, 1'b0, 2'b00);
        repeat (5) step(1'b0, 1'b1, 2'b01);
        step(1'b0, 1'b0, 2'b00);
        check_outputs("pre_abort", 1'b1, 1'b0, 16'h001f, 5'd5);
        #2 rst_n = 1'b0;
        #1 check_outputs("abort", 1'b0, 1'b0, 16'h0000, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All-zero run, golden 0.
        golden_sig = 16'h0000;
        step(1'b1, 1'b0, 2'b00);
        repeat (15) step(1'b0, 1'b1, 2'b00);
        step(1'b0, 1'b1, 2'b00);
        check_outputs("zero.pre_last", 1'b1, 1'b0, 16'h0000, 5'd15);
        step(1'b0, 1'b0, 2'b00);
        check_outputs("zero", 1'b0, 1'b1, 16'h0000, 5'd16);
        check_eq("zero.pass", 32'(pass), 32'd1);
        check_eq("zero.fail", 32'(fail), 32'd0);
        // DONE ignores responses; count stays at 16.
        step(1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b1, 2'b11);
        step(1'b0, 1'b0, 2'b00);
        check_outputs("frozen", 1'b0, 1'b1, 16'h0000, 5'd16);

        // Single-bit walk: 0x0001 shifted 15 times, no feedback.
        do_run(2'b01, 1'b0, 1'b0);
        check_outputs("walk", 1'b0, 1'b1, 16'h8000, 5'd16);
        golden_sig = 16'h8000;
        #1 check_eq("walk.pass", 32'({pass, fail}), 32'b10);
        golden_sig = 16'h1021;
        #1 check_eq("walk.fail", 32'({pass, fail}), 32'b01);

        // 2'b10 first: MSB reaches bit 15 after 14 shifts, last shift folds POLY.
        do_run(2'b10, 1'b0, 1'b0);
        check_outputs("poly", 1'b0, 1'b1, 16'h1021, 5'd16);
        check_eq("poly.pass", 32'({pass, fail}), 32'b10);

        // Same responses with gaps and an ignored mid-run start.
        golden_sig = 16'h0000;
        do_run(2'b10, 1'b1, 1'b1);
        check_outputs("gapped", 1'b0, 1'b1, 16'h1021, 5'd16);
        check_eq("gapped.fail", 32'({pass, fail, timeout}), 32'b010);

        // Restart from DONE with a simultaneous response that must be dropped.
        step(1'b1, 1'b1, 2'b11);
        step(1'b0, 1'b0, 2'b00);
        check_outputs("restart", 1'b1, 1'b0, 16'h0000, 5'd0);

        // Three responses (sig 1, 3, 7) then a long idle gap.
        repeat (3) step(1'b0, 1'b1, 2'b01);
        repeat (64) step(1'b0, 1'b0, 2'b00);
        check_outputs("idle63", 1'b1, 1'b0, 16'h0007, 5'd3);
        step(1'b0, 1'b0, 2'b00);
`ifdef MISR_TIMEOUT_EN
        check_outputs("timeout", 1'b0, 1'b1, 16'h0007, 5'd3);
        check_eq("timeout.flags", 32'({pass, fail, timeout}), 32'b011);
`else
        repeat (20) step(1'b0, 1'b0, 2'b00);
        check_outputs("no_watchdog", 1'b1, 1'b0, 16'h0007, 5'd3);
        check_eq("no_watchdog.flags", 32'({pass, fail, timeout}), 32'b000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
